// File: rtl/param_reg_pkg.sv
// param_reg_pkg: shared types and constants for the param_reg block.
// FSM states, register map, reset values and CFG read-only field.
package param_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_RELEASE
  } state_t;

  localparam int CNT_W = 3;

  localparam int A_CTRL    = 'h00;
  localparam int A_SCRATCH = 'h01;
  localparam int A_CFG     = 'h02;
  localparam int A_STATUS  = 'h03;
  localparam int A_IRQ_EN  = 'h04;

  localparam int RST_CTRL    = 'h10;
  localparam int RST_SCRATCH = 'h10;
  localparam int RST_CFG_RW  = 'h10;
  localparam int RST_STATUS  = 'h00;
  localparam int RST_IRQ_EN  = 'h00;

  // top two CFG bits are read-only and always read as 2'b01
  localparam logic [1:0] CFG_RO_BITS = 2'b11;
  localparam logic [1:0] CFG_RO_VAL  = 2'b01;
  localparam logic [7:0] CFG_RO_MASK8 = 8'hC0;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/param_reg_mem.sv
// param_reg_mem: single-port word array for the param_reg block.
// Synchronous write, combinational read, synchronous clear on reset.
module param_reg_mem
  import param_reg_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam logic [IDX_W:0] DEPTH_V = (IDX_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;

  assign in_range = ({1'b0, idx} < DEPTH_V);

  // word storage: cleared on reset, written when selected
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[IDX_W'(i)] <= '0;
      end
    end else if (we && in_range) begin
      mem[idx] <= wdata;
    end
  end

  // combinational read, zero for out-of-range index
  always_comb begin
    rdata = '0;
    if (in_range) begin
      rdata = mem[idx];
    end
  end

endmodule

// File: rtl/param_reg_dut.sv
// param_reg_dut: 4-phase request/ack register block with CSRs and memory.
// Fixed-latency FSM, W1C status with set priority, level interrupt.
module param_reg_dut
  import param_reg_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 16,
  parameter int MEM_BASE  = 'h08,
  parameter int ACK_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr1rd0,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] hw_event,
  output logic              irq
);

  localparam int IDX_W = idx_w(MEM_DEPTH);

  localparam logic [ADDR_W:0] MEM_LO =
    (ADDR_W+1)'(MEM_BASE);
  localparam logic [ADDR_W:0] MEM_HI =
    (ADDR_W+1)'(MEM_BASE + MEM_DEPTH);

  localparam logic [DATA_W-1:0] RO_MASK =
    {CFG_RO_BITS, {(DATA_W-2){1'b0}}};
  localparam logic [DATA_W-1:0] RO_VAL =
    {CFG_RO_VAL, {(DATA_W-2){1'b0}}};
  localparam logic [DATA_W-1:0] CFG_RST =
    RO_VAL | (DATA_W'(RST_CFG_RW) & ~RO_MASK);

  state_t state, state_n;

  logic [CNT_W-1:0]  cnt;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;

  logic [DATA_W-1:0] ctrl;
  logic [DATA_W-1:0] scratch;
  logic [DATA_W-1:0] cfg;
  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] irq_en;

  logic              start;
  logic              commit;
  logic              wr_en;
  logic              sel_ctrl;
  logic              sel_scratch;
  logic              sel_cfg;
  logic              sel_status;
  logic              sel_irq_en;
  logic              csr_hit;
  logic              mem_hit;
  logic              mapped;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] clr;

  assign start  = (state == ST_IDLE) && req;
  assign commit = (state == ST_WAIT) && (cnt == '0);
  assign wr_en  = commit && wr_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:    if (req) state_n = ST_WAIT;
      ST_WAIT:    if (cnt == '0) state_n = ST_RESP;
      ST_RESP:    state_n = ST_RELEASE;
      ST_RELEASE: if (!req) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // FSM outputs: ack/err only while responding, irq from registers
  always_comb begin
    ack = (state == ST_RESP);
    err = (state == ST_RESP) && err_q;
    irq = |(status & irq_en);
  end

  // wait counter and request capture at acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (start) begin
      cnt    <= CNT_W'(ACK_LAT);
      wr_q   <= wr1rd0;
      addr_q <= addr;
      data_q <= data;
    end else if ((state == ST_WAIT) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // address decode on the latched address
  always_comb begin
    sel_ctrl    = (addr_q == ADDR_W'(A_CTRL));
    sel_scratch = (addr_q == ADDR_W'(A_SCRATCH));
    sel_cfg     = (addr_q == ADDR_W'(A_CFG));
    sel_status  = (addr_q == ADDR_W'(A_STATUS));
    sel_irq_en  = (addr_q == ADDR_W'(A_IRQ_EN));
    csr_hit     = sel_ctrl | sel_scratch | sel_cfg
                | sel_status | sel_irq_en;
    mem_hit     = !csr_hit
                && ({1'b0, addr_q} >= MEM_LO)
                && ({1'b0, addr_q} <  MEM_HI);
    mapped      = csr_hit | mem_hit;
    mem_idx     = IDX_W'(addr_q - ADDR_W'(MEM_BASE));
  end

  // read mux, zero for unmapped addresses
  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_ctrl:    rd_mux = ctrl;
      sel_scratch: rd_mux = scratch;
      sel_cfg:     rd_mux = cfg;
      sel_status:  rd_mux = status;
      sel_irq_en:  rd_mux = irq_en;
      mem_hit:     rd_mux = mem_rdata;
      default:     rd_mux = '0;
    endcase
  end

  assign clr = (wr_en && sel_status) ? data_q : '0;

  // CSR storage; status set beats same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl    <= DATA_W'(RST_CTRL);
      scratch <= DATA_W'(RST_SCRATCH);
      cfg     <= CFG_RST;
      status  <= DATA_W'(RST_STATUS);
      irq_en  <= DATA_W'(RST_IRQ_EN);
    end else begin
      if (wr_en && sel_ctrl)    ctrl    <= data_q;
      if (wr_en && sel_scratch) scratch <= data_q;
      if (wr_en && sel_cfg)
        cfg <= (data_q & ~RO_MASK) | RO_VAL;
      if (wr_en && sel_irq_en)  irq_en  <= data_q;
      status <= (status & ~clr) | hw_event;
    end
  end

  // response capture: read value taken before the write lands
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
      err_q   <= 1'b0;
    end else if (commit) begin
      err_q <= !mapped;
      if (!wr_q || !mapped) rd_data <= rd_mux;
    end
  end

  param_reg_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en && mem_hit),
    .idx   (mem_idx),
    .wdata (data_q),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_param_reg_dut.sv
// tb_param_reg_dut: randomized self-checking bench for param_reg_dut.
// Reference model holds the register map as plain variables.
module tb_param_reg_dut;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 16;
  localparam int BASE  = 8;
  localparam int LAT   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic          wr1rd0;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          ack;
  logic          err;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] hw_event;
  logic          irq;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_ctrl, m_scratch, m_cfg, m_status, m_irq_en;
  logic [7:0] m_mem [DEPTH];

  always #5 clk = ~clk;

  param_reg_dut #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .MEM_DEPTH (DEPTH),
    .MEM_BASE  (BASE),
    .ACK_LAT   (LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .wr1rd0   (wr1rd0),
    .addr     (addr),
    .data     (data),
    .ack      (ack),
    .err      (err),
    .rd_data  (rd_data),
    .hw_event (hw_event),
    .irq      (irq)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void mdl_reset();
    m_ctrl    = 8'h10;
    m_scratch = 8'h10;
    m_cfg     = 8'h50;
    m_status  = 8'h00;
    m_irq_en  = 8'h00;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
  endfunction

  function automatic bit in_mem(input logic [7:0] a);
    return (int'(a) >= BASE) && (int'(a) < BASE + DEPTH);
  endfunction

  function automatic void mdl_rd(input  logic [7:0] a,
                                 output logic [7:0] v,
                                 output bit         e);
    v = 8'h00;
    e = 1'b0;
    case (a)
      8'h00:   v = m_ctrl;
      8'h01:   v = m_scratch;
      8'h02:   v = m_cfg;
      8'h03:   v = m_status;
      8'h04:   v = m_irq_en;
      default: begin
        if (in_mem(a)) v = m_mem[int'(a) - BASE];
        else e = 1'b1;
      end
    endcase
  endfunction

  function automatic void mdl_wr(input logic [7:0] a,
                                 input logic [7:0] d);
    case (a)
      8'h00:   m_ctrl    = d;
      8'h01:   m_scratch = d;
      8'h02:   m_cfg     = 8'h40 | (d & 8'h3F);
      8'h03:   m_status  = m_status & ~d;
      8'h04:   m_irq_en  = d;
      default: if (in_mem(a)) m_mem[int'(a) - BASE] = d;
    endcase
  endfunction

  // one full 4-phase transaction; hw is pulsed into the commit cycle
  task automatic txn(input bit         wr,
                     input logic [7:0] a,
                     input logic [7:0] d,
                     input logic [7:0] hw);
    logic [7:0] ev;
    bit         ee;
    int         ack_at;
    int         c;
    logic       err_s;
    logic [7:0] rd_s;
    mdl_rd(a, ev, ee);
    @(negedge clk);
    req    = 1'b1;
    wr1rd0 = wr;
    addr   = a;
    data   = d;
    @(posedge clk);
    #1;
    addr   = 8'($urandom);
    data   = 8'($urandom);
    wr1rd0 = 1'($urandom);
    ack_at = -1;
    c      = 0;
    err_s  = 1'b0;
    rd_s   = 8'h00;
    while (c < 10 && ack_at < 0) begin
      if (c == LAT) hw_event = hw;
      @(posedge clk);
      #1;
      hw_event = 8'h00;
      c++;
      if (ack) begin
        ack_at = c;
        err_s  = err;
        rd_s   = rd_data;
      end
    end
    chk($sformatf("ack_lat a=%0h", a), ack_at, LAT + 1);
    chk($sformatf("err a=%0h", a), {31'b0, err_s}, {31'b0, ee});
    if (!wr || ee)
      chk($sformatf("rd_data a=%0h", a), {24'b0, rd_s}, {24'b0, ev});
    req = 1'b0;
    @(posedge clk);
    #1;
    chk("ack_one_cycle", {30'b0, ack, err}, 32'd0);
    @(posedge clk);
    #1;
    if (wr) mdl_wr(a, d);
    m_status = m_status | hw;
    chk("irq", {31'b0, irq}, {31'b0, |(m_status & m_irq_en)});
  endtask

  task automatic pulse_hw(input logic [7:0] v);
    @(negedge clk);
    hw_event = v;
    @(posedge clk);
    #1;
    hw_event = 8'h00;
    m_status = m_status | v;
    chk("irq_after_event", {31'b0, irq},
        {31'b0, |(m_status & m_irq_en)});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    req      = 1'b0;
    wr1rd0   = 1'b0;
    addr     = 8'h00;
    data     = 8'h00;
    hw_event = 8'h00;
    mdl_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rd_data", {24'b0, rd_data}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    reset = 1'b0;

    for (int a = 0; a < 5; a++) txn(1'b0, 8'(a), 8'h00, 8'h00);

    txn(1'b1, 8'h02, 8'hFF, 8'h00);
    txn(1'b0, 8'h02, 8'h00, 8'h00);
    txn(1'b1, 8'(BASE + 15), 8'hA5, 8'h00);
    txn(1'b0, 8'(BASE + 15), 8'h00, 8'h00);

    txn(1'b1, 8'h04, 8'h01, 8'h00);
    pulse_hw(8'h81);
    txn(1'b0, 8'h03, 8'h00, 8'h00);
    txn(1'b1, 8'h03, 8'h01, 8'h01);
    txn(1'b0, 8'h03, 8'h00, 8'h00);
    txn(1'b1, 8'h03, 8'h81, 8'h00);
    txn(1'b0, 8'h03, 8'h00, 8'h00);

    txn(1'b0, 8'(BASE + DEPTH), 8'h00, 8'h00);
    txn(1'b1, 8'(BASE + DEPTH), 8'hEE, 8'h00);
    txn(1'b1, 8'h07, 8'h5A, 8'h00);
    for (int i = 0; i < DEPTH; i++)
      txn(1'b0, 8'(BASE + i), 8'h00, 8'h00);

    repeat (80) begin
      logic [7:0] ra, rd, rh;
      bit         rw;
      ra = 8'($urandom_range(0, 31));
      rw = 1'($urandom_range(0, 1));
      rd = 8'($urandom);
      rh = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      txn(rw, ra, rd, rh);
      if ($urandom_range(0, 4) == 0) pulse_hw(8'($urandom));
    end
    for (int a = 0; a < 5; a++) txn(1'b0, 8'(a), 8'h00, 8'h00);
    txn(1'b1, 8'h01, 8'hC3, 8'h00);
    txn(1'b1, 8'(BASE + 3), 8'h3C, 8'h00);

    @(negedge clk);
    req    = 1'b1;
    wr1rd0 = 1'b1;
    addr   = 8'h01;
    data   = 8'h33;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("ack_in_reset", {31'b0, ack}, 32'd0);
      if (i == 1) req = 1'b0;
    end
    reset = 1'b0;
    mdl_reset();
    chk("post_rst_rd_data", {24'b0, rd_data}, 32'd0);
    chk("post_rst_irq", {31'b0, irq}, 32'd0);
    for (int a = 0; a < 5; a++) txn(1'b0, 8'(a), 8'h00, 8'h00);
    for (int i = 0; i < DEPTH; i++)
      txn(1'b0, 8'(BASE + i), 8'h00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
